// File: rtl/seg7_display_mux_pkg.sv
// Shared constants for the seg7_display_mux block: hex segment patterns,
// the all-off segment pattern and the default refresh divider.
package seg7_display_mux_pkg;

   // Default clock cycles spent on each digit slot.
   localparam int REFRESH_DIV_DEFAULT = 100000;

   // Active-low segments, bit order g..a; every segment off.
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low hex patterns, indexed by nibble value (entry 15 listed first).
   localparam logic [15:0][6:0] SEG_PATTERNS = {
      7'h0E,  // F
      7'h06,  // E
      7'h21,  // d
      7'h46,  // C
      7'h03,  // b
      7'h08,  // A
      7'h10,  // 9
      7'h00,  // 8
      7'h78,  // 7
      7'h02,  // 6
      7'h12,  // 5
      7'h19,  // 4
      7'h30,  // 3
      7'h24,  // 2
      7'h79,  // 1
      7'h40   // 0
   };

endpackage

// File: rtl/seg7_display_mux_hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-low seven-segment decoder.
module hex_to_seg7
   import seg7_display_mux_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Table lookup of the active-low pattern for the nibble.
   always_comb begin
      seg = SEG_PATTERNS[nibble];
   end

endmodule

// File: rtl/seg7_display_mux.sv
// seg7_display_mux: time-multiplexed driver for a 4-digit common-anode
// seven-segment display. The value is snapshotted once per scan frame so a
// frame never mixes two values. Optional build macro
// SEG7_LEADING_ZERO_BLANK_EN turns off leading zero digits 3..1.
module seg7_display_mux
   import seg7_display_mux_pkg::*;
#(
   parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
)
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] VALUE,
   input  logic [3:0]  DOTS,
   input  logic        BLANK,
   output logic [3:0]  SEG_SELECT_OUT,
   output logic [7:0]  HEX_OUT
);

   localparam int              CW       = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0]   TERMINAL = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] prescale_reg;
   logic          tick;
   logic [1:0]    index_reg;
   logic [15:0]   snapshot_reg;
   logic [3:0]    nibble;
   logic [6:0]    seg_decoded;
   logic [6:0]    seg_shown;
   logic [3:0]    select_next;
   logic [7:0]    hex_next;

   assign tick = (prescale_reg == TERMINAL);

   // Prescaler: counts 0..REFRESH_DIV-1 and wraps on the terminal count.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         prescale_reg <= '0;
      end else if (tick) begin
         prescale_reg <= '0;
      end else begin
         prescale_reg <= prescale_reg + 1'b1;
      end
   end

   // Digit index advances per tick; the value is captured when the index wraps
   // so that all four digits of the next frame come from the same word.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         index_reg    <= 2'd0;
         snapshot_reg <= 16'h0000;
      end else if (tick) begin
         index_reg <= index_reg + 2'd1;
         if (index_reg == 2'd3) begin
            snapshot_reg <= VALUE;
         end
      end
   end

   // Select the nibble of the snapshot belonging to the current digit.
   always_comb begin
      nibble = snapshot_reg[{index_reg, 2'b00} +: 4];
   end

   hex_to_seg7 u_hex_to_seg7 (
      .nibble (nibble),
      .seg    (seg_decoded)
   );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   // lead_zero[n] is set when nibble n and every higher nibble are zero;
   // digit 0 is always shown so a zero value still displays "0".
   logic [3:0] lead_zero;

   assign lead_zero[0] = 1'b0;

   generate
      for (genvar gi = 1; gi < 4; gi++) begin : g_lead_zero
         assign lead_zero[gi] = (snapshot_reg[15:gi*4] == '0);
      end
   endgenerate

   // Replace the decoded pattern with all-off for a leading zero digit.
   always_comb begin
      seg_shown = lead_zero[index_reg] ? SEG_BLANK : seg_decoded;
   end
`else
   // Every digit is decoded as-is.
   always_comb begin
      seg_shown = seg_decoded;
   end
`endif

   // Next output values: one-cold anode select (all off while blanked) and
   // the segment pattern with the live decimal-point request.
   always_comb begin
      select_next = ~(4'b0001 << index_reg);
      if (BLANK) begin
         select_next = 4'b1111;
      end
      hex_next = {~DOTS[index_reg], seg_shown};
   end

   // Registered outputs, driven from the index one cycle after it changes.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         SEG_SELECT_OUT <= 4'b1111;
         HEX_OUT        <= 8'hFF;
      end else begin
         SEG_SELECT_OUT <= select_next;
         HEX_OUT        <= hex_next;
      end
   end

endmodule

// File: tb/tb_seg7_display_mux.sv
// Directed testbench for seg7_display_mux with REFRESH_DIV = 4 (4 cycles per
// digit, 16 cycles per frame). Expected values are hand-computed per slot.
module tb_seg7_display_mux;

   logic        clk;
   logic        reset;
   logic [15:0] value;
   logic [3:0]  dots;
   logic        blank;
   logic [3:0]  seg_select;
   logic [7:0]  hex_out;

   int checks = 0;
   int errors = 0;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   localparam logic [7:0] ZHEX = 8'hFF;  // leading zero digit switched off
`else
   localparam logic [7:0] ZHEX = 8'hC0;  // zero digit, DP off
`endif

   seg7_display_mux #(.REFRESH_DIV(4)) dut (
      .CLK            (clk),
      .RESET          (reset),
      .VALUE          (value),
      .DOTS           (dots),
      .BLANK          (blank),
      .SEG_SELECT_OUT (seg_select),
      .HEX_OUT        (hex_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance n cycles, checking select and segments after each edge.
   task automatic slot(input string tag, input logic [3:0] sel, input logic [7:0] hex, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         check_value({tag, "_sel"}, {4'h0, seg_select}, {4'h0, sel});
         check_value({tag, "_hex"}, hex_out, hex);
      end
      $display("slot %s: sel=%b hex=%02h x%0d", tag, sel, hex, n);
   endtask

   // Advance n cycles, checking only the anode select.
   task automatic slot_sel(input string tag, input logic [3:0] sel, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         check_value({tag, "_sel"}, {4'h0, seg_select}, {4'h0, sel});
      end
      $display("slot %s: sel=%b x%0d", tag, sel, n);
   endtask

   initial begin
      reset = 1'b1;
      value = 16'h1A3F;
      dots  = 4'b0000;
      blank = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_value("rst_sel", {4'h0, seg_select}, 8'h0F);
      check_value("rst_hex", hex_out, 8'hFF);
      $display("reset: sel=%b hex=%02h", seg_select, hex_out);
      reset = 1'b0;

      // Frame 1 shows the reset snapshot (zero).
      slot("f1_d0", 4'b1110, 8'hC0, 4);
      slot("f1_d1", 4'b1101, ZHEX, 4);
      slot("f1_d2", 4'b1011, ZHEX, 4);
      slot("f1_d3", 4'b0111, ZHEX, 4);

      // Frame 2 shows 1A3F: F, 3, A, 1.
      slot("f2_d0", 4'b1110, 8'h8E, 4);
      slot("f2_d1", 4'b1101, 8'hB0, 4);
      slot("f2_d2", 4'b1011, 8'h88, 4);
      slot("f2_d3", 4'b0111, 8'hF9, 4);

      // Frame 3: VALUE changes while digit 2 is shown; no tearing.
      slot("f3_d0", 4'b1110, 8'h8E, 4);
      slot("f3_d1", 4'b1101, 8'hB0, 4);
      slot("f3_d2a", 4'b1011, 8'h88, 1);
      value = 16'hEEEE;
      slot("f3_d2b", 4'b1011, 8'h88, 3);
      slot("f3_d3", 4'b0111, 8'hF9, 4);

      // Frame 4: new snapshot EEEE on every digit.
      slot("f4_d0", 4'b1110, 8'h86, 4);
      slot("f4_d1", 4'b1101, 8'h86, 4);
      slot("f4_d2", 4'b1011, 8'h86, 4);
      slot("f4_d3", 4'b0111, 8'h86, 4);

      // Frame 5: decimal point on digit 2 only.
      dots = 4'b0100;
      slot("f5_d0", 4'b1110, 8'h86, 4);
      slot("f5_d1", 4'b1101, 8'h86, 4);
      slot("f5_d2", 4'b1011, 8'h06, 4);
      slot("f5_d3", 4'b0111, 8'h86, 4);
      dots = 4'b0000;

      // Frame 6: 3-cycle BLANK pulse during digit 1, seen one cycle later.
      slot("f6_d0", 4'b1110, 8'h86, 4);
      slot("f6_d1a", 4'b1101, 8'h86, 1);
      blank = 1'b1;
      slot_sel("f6_blank", 4'b1111, 3);
      blank = 1'b0;
      slot("f6_d2", 4'b1011, 8'h86, 4);
      slot("f6_d3", 4'b0111, 8'h86, 4);

      // Frame 7: reset asserted during digit 3.
      slot("f7_d0", 4'b1110, 8'h86, 4);
      slot("f7_d1", 4'b1101, 8'h86, 4);
      slot("f7_d2", 4'b1011, 8'h86, 4);
      slot("f7_d3", 4'b0111, 8'h86, 1);
      reset = 1'b1;
      blank = 1'b1;
      slot("f7_rst", 4'b1111, 8'hFF, 1);
      reset = 1'b0;
      blank = 1'b0;

      // Restart from digit 0 of a zero snapshot; load 0050 for the next frame.
      slot("f8_d0", 4'b1110, 8'hC0, 4);
      value = 16'h0050;
      slot("f8_d1", 4'b1101, ZHEX, 4);
      slot("f8_d2", 4'b1011, ZHEX, 4);
      slot("f8_d3", 4'b0111, ZHEX, 4);

      // Frame 9: snapshot 0050.
      slot("f9_d0", 4'b1110, 8'hC0, 4);
      slot("f9_d1", 4'b1101, 8'h92, 4);
      slot("f9_d2", 4'b1011, ZHEX, 4);
      slot("f9_d3", 4'b0111, ZHEX, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_display_mux.md
SEG7_DISPLAY_MUX -- requirements
Module: seg7_display_mux

Interface
REQ-001 Parameter: REFRESH_DIV, default 100000, clock cycles per digit slot (legal range 2..2^20).
REQ-002 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 VALUE  input  16  value to display, four hex nibbles; digit 0 = VALUE[3:0].
REQ-005 DOTS  input  4  decimal-point request per digit, active high; DOTS[n] belongs to digit n.
REQ-006 BLANK  input  1  active high; turns all digits off.
REQ-007 SEG_SELECT_OUT  output  4  digit anode select, active low, one-cold; bit n = digit n.
REQ-008 HEX_OUT  output  8  segment cathodes, active low; [6:0] = g..a, [7] = DP.

Function
REQ-009 The prescaler SHALL count 0..REFRESH_DIV-1, wrap to 0, and assert an internal tick for one cycle at terminal count.
REQ-010 The digit index (2 bits) SHALL advance by 1 on each tick and wrap 3 -> 0.
REQ-011 A 16-bit snapshot SHALL load VALUE on the tick that wraps the index 3 -> 0; all four digits of a scan frame SHALL show the same snapshot, with no tearing.
REQ-012 The snapshot SHALL hold while no wrap tick occurs, regardless of VALUE changes.
REQ-013 SEG_SELECT_OUT and HEX_OUT SHALL be registered; they reflect the current index and snapshot exactly one cycle after the index changes.
REQ-014 HEX_OUT[6:0] SHALL be the standard active-low hex pattern of the selected nibble (0 = 7'h40, 1 = 7'h79, 3 = 7'h30, A = 7'h08, E = 7'h06, F = 7'h0E).
REQ-015 HEX_OUT[7] SHALL equal ~DOTS[index], sampled live rather than from the snapshot.
REQ-016 When BLANK = 1, SEG_SELECT_OUT SHALL be 4'b1111 on the next cycle; the prescaler and index keep running.
REQ-017 The output register SHALL never drive more than one SEG_SELECT_OUT bit low in any cycle.

Reset
REQ-018 On RESET = 1 at posedge CLK: prescaler = 0, index = 0, snapshot = 16'h0000, SEG_SELECT_OUT = 4'b1111, HEX_OUT = 8'hFF.
REQ-019 On the first cycle after RESET deasserts, outputs SHALL show digit 0 of snapshot 0 (SEG_SELECT_OUT = 4'b1110, HEX_OUT[6:0] = 7'h40).
REQ-020 RESET asserted mid-scan SHALL override tick, snapshot load and BLANK in the same cycle.

Configuration
REQ-021 Macro SEG7_LEADING_ZERO_BLANK_EN: when defined, digits 3..1 SHALL output HEX_OUT[6:0] = 7'h7F when their nibble and all higher nibbles of the snapshot are zero.
REQ-022 Under SEG7_LEADING_ZERO_BLANK_EN, digit 0 SHALL never be blanked, and DP and SEG_SELECT_OUT SHALL be unaffected.
REQ-023 When SEG7_LEADING_ZERO_BLANK_EN is undefined, all digits SHALL always be decoded; no blanking logic is synthesised.

Structure
REQ-024 A shared package/include file SHALL hold the 16-entry segment pattern constants, the blank pattern 7'h7F and the REFRESH_DIV default.
REQ-025 The nibble-to-segment decode SHALL be a combinational sub-module, hex_to_seg7 (4-bit in, 7-bit active-low out), instantiated once on the muxed nibble.
REQ-026 The prescaler width SHALL be $clog2(REFRESH_DIV); no other parameters.

Verification (bench REFRESH_DIV = 4)
REQ-027 Reset, then hold VALUE = 16'h1A3F, DOTS = 0 for 2 frames -> second frame shows HEX_OUT 8'h8E, 8'hB0, 8'h88, 8'hF9 with SEG_SELECT_OUT 1110, 1101, 1011, 0111, each for 4 cycles.
REQ-028 Change VALUE from 16'h1A3F to 16'hEEEE while digit 2 is shown -> digits 2 and 3 still show A and 1; the next frame shows 7'h06 on all digits.
REQ-029 DOTS = 4'b0100 -> HEX_OUT[7] = 0 only while SEG_SELECT_OUT = 1011.
REQ-030 Pulse BLANK for 3 cycles mid-frame -> SEG_SELECT_OUT = 1111 for exactly those 3 cycles, delayed by one; digit sequencing timing is unchanged afterwards.
REQ-031 Assert RESET during digit 3 -> next cycle outputs 1111/8'hFF; one cycle after release, 1110/8'hC0.
REQ-032 With SEG7_LEADING_ZERO_BLANK_EN, VALUE = 16'h0050 -> digits 3 and 2 = 7'h7F, digit 1 = 5 (7'h12), digit 0 = 7'h40; VALUE = 0 -> only digit 0 lit, showing 7'h40.
